i2c_slave_fsm: RTL and testbench

//  I2C target (slave) endpoint. It answers the I2C master FSM on the same bus.
//  SCL/SDA are oversampled on a fast system clock; the block is never clocked by SCL.
//  - Detects START/STOP and matches a 7-bit address.
//  - Receives write bytes and ACKs them; returns read bytes and samples the master ACK/NACK.
//  - Drives the bus open-drain via output enables (oe=1 pulls the line low).

---
 rtl/i2c_slave_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_slave_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_fsm.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match, byte write/read with ACK.
// Define I2C_CLK_STRETCH_EN to hold SCL low at a read-byte load point until tx_valid is high.
module i2c_slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i2c_clk_in,
    input  logic       resetN,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       rw,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDRESS    = 4'd1,
        ADDR_ACK   = 4'd2,
        WRITE_DATA = 4'd3,
        WRITE_ACK  = 4'd4,
        READ_DATA  = 4'd5,
        READ_ACK   = 4'd6
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    // Synchronizers and edge register idle high so reset never creates a bus event.
    always_ff @(posedge i2c_clk_in or negedge resetN) begin
        if (!resetN) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

    state_t     state_q, state_n;
    logic [2:0] cnt_q, cnt_n;
    logic [7:0] shreg_q, shreg_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       phase_q, phase_n;
    logic       pend_q, pend_n;
    logic       sda_oe_q, sda_oe_n;
    logic       rx_valid_q, rx_valid_n;
    logic       rw_q, rw_n;
    logic       load_req;

    always_ff @(posedge i2c_clk_in or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            phase_q    <= 1'b0;
            pend_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            shreg_q    <= shreg_n;
            rx_data_q  <= rx_data_n;
            phase_q    <= phase_n;
            pend_q     <= pend_n;
            sda_oe_q   <= sda_oe_n;
            rx_valid_q <= rx_valid_n;
            rw_q       <= rw_n;
        end
    end

    // phase_q: in the ACK states it marks the second half (ACK driven / master ACK seen).
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        shreg_n    = shreg_q;
        rx_data_n  = rx_data_q;
        phase_n    = phase_q;
        pend_n     = pend_q;
        sda_oe_n   = sda_oe_q;
        rx_valid_n = 1'b0;
        rw_n       = rw_q;
        load_req   = 1'b0;
        tx_load    = 1'b0;
        if (start_ev) begin
            state_n  = ADDRESS;
            cnt_n    = 3'd7;
            sda_oe_n = 1'b0;
            phase_n  = 1'b0;
            pend_n   = 1'b0;
        end else if (stop_ev) begin
            state_n  = IDLE;
            cnt_n    = 3'd7;
            sda_oe_n = 1'b0;
            phase_n  = 1'b0;
            pend_n   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDRESS: if (scl_rise) begin
                    shreg_n = {shreg_q[6:0], sda_s};
                    if (cnt_q == 3'd0) begin
                        if (shreg_q[6:0] == SLAVE_ADDR) begin
                            rw_n    = sda_s;
                            phase_n = 1'b0;
                            state_n = ADDR_ACK;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt_q - 3'd1;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_n = 1'b1;
                        phase_n  = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        cnt_n    = 3'd7;
                        if (rw_q) begin
                            state_n  = READ_DATA;
                            load_req = 1'b1;
                        end else begin
                            state_n = WRITE_DATA;
                        end
                    end
                end
                WRITE_DATA: if (scl_rise) begin
                    shreg_n = {shreg_q[6:0], sda_s};
                    if (cnt_q == 3'd0) begin
                        rx_data_n  = {shreg_q[6:0], sda_s};
                        rx_valid_n = 1'b1;
                        phase_n    = 1'b0;
                        state_n    = WRITE_ACK;
                    end else begin
                        cnt_n = cnt_q - 3'd1;
                    end
                end
                WRITE_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_n = 1'b1;
                        phase_n  = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        cnt_n    = 3'd7;
                        state_n  = WRITE_DATA;
                    end
                end
                READ_DATA: if (!pend_q && scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        state_n  = READ_ACK;
                    end else begin
                        cnt_n    = cnt_q - 3'd1;
                        shreg_n  = {shreg_q[6:0], 1'b0};
                        sda_oe_n = ~shreg_q[6];
                    end
                end
                READ_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_s) state_n = IDLE;
                        else       phase_n = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_n  = 1'b0;
                        cnt_n    = 3'd7;
                        state_n  = READ_DATA;
                        load_req = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase

            // The first read bit goes out in the same clk the byte is captured.
            if (load_req || pend_q) begin
`ifdef I2C_CLK_STRETCH_EN
                if (tx_valid) begin
                    tx_load  = 1'b1;
                    pend_n   = 1'b0;
                    shreg_n  = tx_data;
                    sda_oe_n = ~tx_data[7];
                end else begin
                    pend_n = 1'b1;
                end
`else
                tx_load  = 1'b1;
                shreg_n  = tx_data;
                sda_oe_n = ~tx_data[7];
`endif
            end
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    // pend_q drops at the edge ending the tx_load clk, so SCL is freed one clk later.
    assign scl_oe = pend_q;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
    assign scl_oe          = 1'b0;
`endif

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rw       = rw_q;
    assign busy     = (state_q != IDLE);
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: a bit-level I2C master on a wired-AND bus plus rx/tx scoreboards.
module tb_i2c_slave_fsm;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b1;
    logic       sda_oe, scl_oe, rx_valid, tx_load, rw, busy;
    logic [7:0] rx_data;
    logic [3:0] state;
    logic       scl_line, sda_line;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_fsm #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .i2c_clk_in(clk), .resetN(rst_n), .scl_in(scl_line), .sda_in(sda_line),
        .tx_data(tx_data), .tx_valid(tx_valid), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_load(tx_load), .rw(rw),
        .busy(busy), .state(state)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: records DUT-produced events; only this process writes these.
    logic [7:0] got_rx[$];
    int n_txload = 0, n_sdaoe = 0, n_scloe = 0, n_both = 0;
    always @(negedge clk) begin
        if (rx_valid) got_rx.push_back(rx_data);
        if (tx_load) n_txload++;
        if (sda_oe) n_sdaoe++;
        if (scl_oe) n_scloe++;
        if (rx_valid && tx_load) n_both++;
    end

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int         rx_rd = 0;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; step(Q);
        sda_m = 1'b0; step(2*Q);
        scl_m = 1'b0;
    endtask

    task automatic bus_rstart();
        step(Q); sda_m = 1'b1;
        step(Q); scl_m = 1'b1;
        step(Q); sda_m = 1'b0;
        step(Q); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        step(Q); sda_m = 1'b0;
        step(Q); scl_m = 1'b1;
        step(Q); sda_m = 1'b1;
        step(2*Q);
    endtask

    task automatic send_bit(input logic b);
        step(Q); sda_m = b;
        step(Q); scl_m = 1'b1;
        step(2*Q); scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        step(Q); sda_m = 1'b1;
        step(Q); scl_m = 1'b1;
        step(Q); b = sda_line;
        step(Q); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // Compares the bytes the master read against what was queued with tx_data.
    task automatic tx_compare(input string tag, input logic [7:0] got);
        logic [7:0] e;
        e = exp_tx.pop_front();
        check(tag, got, e);
    endtask

    task automatic rx_compare(input string tag, input int rx0);
        logic [7:0] e;
        check({tag, " count"}, got_rx.size() - rx0, exp_rx.size());
        while (exp_rx.size() > 0 && rx_rd < got_rx.size()) begin
            e = exp_rx.pop_front();
            check({tag, " data"}, got_rx[rx_rd], e);
            rx_rd++;
        end
        exp_rx.delete();
        rx_rd = got_rx.size();
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, sda0, tl0, sc0;

        step(3);
        check("reset sda_oe", sda_oe, 0);
        rst_n = 1'b1;
        step(3);
        check("reset scl_oe", scl_oe, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset tx_load", tx_load, 0);
        check("reset rw", rw, 0);
        check("reset busy", busy, 0);
        check("reset state", state, 4'd0);

        // Write two data bytes
        rx0 = got_rx.size();
        bus_start();
        write_byte(8'hA0, ack); check("t1 addr ack", ack, 1);
        check("t1 rw", rw, 0);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack); check("t1 data0 ack", ack, 1);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack); check("t1 data1 ack", ack, 1);
        bus_stop();
        check("t1 busy after stop", busy, 0);
        check("t1 state after stop", state, 4'd0);
        rx_compare("t1 rx", rx0);

        // Foreign address: no drive at all
        rx0 = got_rx.size();
        sda0 = n_sdaoe;
        bus_start();
        write_byte(8'hA2, ack); check("t2 addr nack", ack, 0);
        check("t2 state idle", state, 4'd0);
        write_byte(8'h77, ack); check("t2 data nack", ack, 0);
        bus_stop();
        check("t2 sda_oe never", n_sdaoe - sda0, 0);
        rx_compare("t2 rx", rx0);

        // Read two bytes, ACK then NACK
        tx_data = 8'h96; exp_tx.push_back(8'h96);
        tl0 = n_txload;
        bus_start();
        write_byte(8'hA1, ack); check("t3 addr ack", ack, 1);
        check("t3 rw", rw, 1);
        step(4);
        tx_data = 8'h0F; exp_tx.push_back(8'h0F);
        read_byte(1'b0, d); tx_compare("t3 byte0", d);
        read_byte(1'b1, d); tx_compare("t3 byte1", d);
        step(4);
        check("t3 sda released", sda_oe, 0);
        check("t3 state idle", state, 4'd0);
        check("t3 tx_load count", n_txload - tl0, 2);
        bus_stop();

        // Write then repeated START into a read
        tx_data = 8'h5A;
        rx0 = got_rx.size();
        bus_start();
        write_byte(8'hA0, ack); check("t4 addr w ack", ack, 1);
        check("t4 rw write", rw, 0);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack); check("t4 data ack", ack, 1);
        bus_rstart();
        check("t4 state address", state, 4'd1);
        write_byte(8'hA1, ack); check("t4 addr r ack", ack, 1);
        check("t4 rw read", rw, 1);
        exp_tx.push_back(8'h5A);
        read_byte(1'b1, d); tx_compare("t4 read", d);
        bus_stop();
        rx_compare("t4 rx", rx0);

        // Asynchronous reset in the middle of a read byte
        tx_data = 8'hC3;
        bus_start();
        write_byte(8'hA1, ack); check("t5 addr ack", ack, 1);
        for (int i = 0; i < 4; i++) recv_bit(ack);
        step(Q);
        check("t5 bit3 driven", sda_oe, 1);
        check("t5 state read", state, 4'd5);
        rst_n = 1'b0;
        #1;
        check("t5 async sda_oe", sda_oe, 0);
        check("t5 async state", state, 4'd0);
        step(3);
        sda_m = 1'b1;
        rst_n = 1'b1;
        step(2);
        scl_m = 1'b1;
        step(2*Q);
        bus_start();
        write_byte(8'hA0, ack); check("t5 ack after reset", ack, 1);
        bus_stop();
        check("t5 busy after stop", busy, 0);

`ifdef I2C_CLK_STRETCH_EN
        // Stretch SCL while the second read byte is not ready
        tx_data = 8'hE7; tx_valid = 1'b1; exp_tx.push_back(8'hE7);
        bus_start();
        write_byte(8'hA1, ack); check("t6 addr ack", ack, 1);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(ack);
            d[i] = ack;
        end
        tx_compare("t6 byte0", d);
        tx_valid = 1'b0;
        tx_data  = 8'h3D; exp_tx.push_back(8'h3D);
        tl0 = n_txload;
        send_bit(1'b0);
        step(3);
        check("t6 stretch start", scl_oe, 1);
        sc0 = n_scloe;
        step(50);
        check("t6 stretch held", scl_oe, 1);
        check("t6 no early load", n_txload - tl0, 0);
        tx_valid = 1'b1;
        step(1);
        check("t6 scl released", scl_oe, 0);
        step(1);
        check("t6 stretch clks", n_scloe - sc0, 51);
        check("t6 tx_load once", n_txload - tl0, 1);
        read_byte(1'b1, d); tx_compare("t6 byte1", d);
        bus_stop();
`else
        check("scl_oe never", n_scloe, 0);
`endif

        check("rx_valid/tx_load overlap", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
